// File: rtl/debounce_pkg.sv
// Shared types for the sensor debouncer: per-channel filter state and
// the mapping from state to the clean output level.
package debounce_pkg;

    typedef enum logic [1:0] {
        S_LOW       = 2'd0,
        S_WAIT_HIGH = 2'd1,
        S_HIGH      = 2'd2,
        S_WAIT_LOW  = 2'd3
    } db_state_t;

    // The accepted level stays high while a falling candidate is being qualified.
    function automatic logic is_high(input db_state_t st);
        return (st == S_HIGH) || (st == S_WAIT_LOW);
    endfunction

endpackage

// File: rtl/sensor_debouncer_if.sv
// Bundle of the tick, raw sensor lines and conditioned outputs between the
// sensor front-end and its consumer.
interface sensor_debouncer_if #(
    parameter int unsigned N_CH = 2
);
    logic            tick;
    logic [N_CH-1:0] sensor_raw;
    logic [N_CH-1:0] sensor_db;
    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] fall;

    modport master (
        output tick,
        output sensor_raw,
        input  sensor_db,
        input  rise,
        input  fall
    );

    modport slave (
        input  tick,
        input  sensor_raw,
        output sensor_db,
        output rise,
        output fall
    );
endinterface

// File: rtl/debounce_channel.sv
// One sensor channel: two-flop synchroniser followed by a tick-paced
// stability filter that emits a clean level and one-cycle edge strobes.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int unsigned STABLE_TICKS = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int unsigned     CNT_W    = $clog2(STABLE_TICKS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1_q;
    logic             sync2_q;
    db_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             s;

    assign s = sync2_q;

    // A mismatch always wins over a tick in the same cycle, and the cycle that
    // enters a WAIT state never counts a tick.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        unique case (state_q)
            S_LOW: begin
                if (s) begin
                    state_d = S_WAIT_HIGH;
                    cnt_d   = '0;
                end
            end
            S_WAIT_HIGH: begin
                if (!s) begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                end else if (tick) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_HIGH;
                        cnt_d   = '0;
                        rise_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            S_HIGH: begin
                if (!s) begin
                    state_d = S_WAIT_LOW;
                    cnt_d   = '0;
                end
            end
            S_WAIT_LOW: begin
                if (s) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                end else if (tick) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_LOW;
                        cnt_d   = '0;
                        fall_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            default: begin
                state_d = S_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= S_LOW;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level = is_high(state_q);
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/sensor_debouncer.sv
// Conditions N_CH raw optical sensor lines into clean levels and edge strobes
// for the downstream parking-lot FSM; channels are fully independent.
module sensor_debouncer #(
    parameter int unsigned N_CH         = 2,
    parameter int unsigned STABLE_TICKS = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            tick,
    input  logic [N_CH-1:0] sensor_raw,
    output logic [N_CH-1:0] sensor_db,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall
);

    genvar ch;
    generate
        for (ch = 0; ch < N_CH; ch++) begin : g_ch
            debounce_channel #(
                .STABLE_TICKS(STABLE_TICKS)
            ) u_channel (
                .clk  (clk),
                .rst  (rst),
                .tick (tick),
                .raw  (sensor_raw[ch]),
                .level(sensor_db[ch]),
                .rise (rise[ch]),
                .fall (fall[ch])
            );
        end
    endgenerate

endmodule

// File: tb/tb_sensor_debouncer.sv
// Randomised and directed stimulus against a mismatch-run reference model;
// expected outputs are queued per clock and compared by a separate monitor.
module tb_sensor_debouncer;

    localparam int unsigned N_CH = 2;
    localparam int unsigned ST   = 4;

    typedef struct packed {
        logic [N_CH-1:0] db;
        logic [N_CH-1:0] rise;
        logic [N_CH-1:0] fall;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    sensor_debouncer_if #(.N_CH(N_CH)) dbif ();

    sensor_debouncer #(
        .N_CH        (N_CH),
        .STABLE_TICKS(ST)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (dbif.tick),
        .sensor_raw(dbif.sensor_raw),
        .sensor_db (dbif.sensor_db),
        .rise      (dbif.rise),
        .fall      (dbif.fall)
    );

    always #5 clk = ~clk;

    int unsigned errors = 0;
    int unsigned checks = 0;
    exp_t        sb_q[$];

    // Reference: raw reaches the filter two clocks late; the clean level flips
    // once ST ticks have been seen on edges where the synchronised value has
    // disagreed with the level for at least one earlier edge, uninterrupted.
    initial begin : model
        logic [N_CH-1:0] d1, d2, s, db;
        int unsigned     run   [N_CH];
        bit              armed [N_CH];
        exp_t            e;
        d1 = '0; d2 = '0; db = '0;
        for (int i = 0; i < N_CH; i++) begin run[i] = 0; armed[i] = 0; end
        forever begin
            @(posedge clk);
            e.rise = '0;
            e.fall = '0;
            if (!rst) begin
                d1 = '0; d2 = '0; db = '0;
                for (int i = 0; i < N_CH; i++) begin run[i] = 0; armed[i] = 0; end
            end else begin
                s  = d2;
                d2 = d1;
                d1 = dbif.sensor_raw;
                for (int i = 0; i < N_CH; i++) begin
                    if (s[i] == db[i]) begin
                        run[i] = 0; armed[i] = 0;
                    end else if (!armed[i]) begin
                        armed[i] = 1; run[i] = 0;
                    end else if (dbif.tick) begin
                        run[i]++;
                        if (run[i] == ST) begin
                            if (db[i]) e.fall[i] = 1'b1; else e.rise[i] = 1'b1;
                            db[i]    = ~db[i];
                            run[i]   = 0;
                            armed[i] = 0;
                        end
                    end
                end
            end
            e.db = db;
            sb_q.push_back(e);
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                checks++;
                if (dbif.sensor_db !== e.db || dbif.rise !== e.rise || dbif.fall !== e.fall) begin
                    errors++;
                    $display("FAIL sb t=%0t got db=%b rise=%b fall=%b required db=%b rise=%b fall=%b",
                             $time, dbif.sensor_db, dbif.rise, dbif.fall, e.db, e.rise, e.fall);
                end
            end
        end
    end

    int unsigned tick_div   = 4;
    int unsigned tick_phase = 0;
    int unsigned rise0_cnt  = 0;

    task automatic cyc(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (dbif.rise[0]) rise0_cnt++;
            tick_phase++;
            if (tick_div == 0) dbif.tick = ($urandom_range(0, 2) == 0);
            else               dbif.tick = ((tick_phase % tick_div) == 0);
        end
    endtask

    task automatic set_raw(input int unsigned ch, input logic v);
        logic [N_CH-1:0] r;
        r     = dbif.sensor_raw;
        r[ch] = v;
        dbif.sensor_raw = r;
    endtask

    initial begin : stim
        logic [N_CH-1:0] r;
        bit              bouncy;
        rst             = 1'b0;
        dbif.tick       = 1'b0;
        dbif.sensor_raw = 2'b11;

        // Reset held with raw high, then released low.
        cyc(3);
        rst = 1'b1;
        dbif.sensor_raw = 2'b00;
        cyc(10);

        // Clean step on ch0; ch1 stays low.
        rise0_cnt = 0;
        set_raw(0, 1'b1);
        cyc(40);
        checks++;
        if (rise0_cnt != 1) begin
            errors++;
            $display("FAIL rise0_once got=%0d required=1", rise0_cnt);
        end

        // Short pulse on ch1 rejected.
        set_raw(1, 1'b1);
        cyc(12);
        set_raw(1, 1'b0);
        cyc(30);

        // Bounce on ch0 while high, then settle low.
        for (int i = 0; i < 10; i++) begin
            set_raw(0, (i % 2 == 0) ? 1'b0 : 1'b1);
            cyc(2);
        end
        set_raw(0, 1'b0);
        cyc(40);

        // Both channels rise together.
        dbif.sensor_raw = 2'b11;
        cyc(40);
        dbif.sensor_raw = 2'b00;
        cyc(40);

        // Reset in the middle of qualifying a rise on ch0.
        set_raw(0, 1'b1);
        cyc(12);
        rst = 1'b0;
        cyc(2);
        rst = 1'b1;
        cyc(40);

        // Randomised phase with random ticks, calm and bouncy segments, rare resets.
        tick_div = 0;
        bouncy   = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) == 0) bouncy = ~bouncy;
            r = dbif.sensor_raw;
            for (int c = 0; c < N_CH; c++) begin
                if (bouncy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 39) == 0))
                    r[c] = ~r[c];
            end
            dbif.sensor_raw = r;
            rst = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
            cyc(1);
        end
        rst = 1'b1;
        cyc(5);

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sensor_debouncer.md
Name: sensor_debouncer

Overview:
Input-conditioning stage directly upstream of the parking-lot FSM. It synchronises the two raw optical sensor lines to clk, rejects glitches and bounce with a tick-paced stability filter, and presents clean levels plus single-cycle edge strobes. The clean levels drive the FSM's sensor1/sensor2 inputs. The tick comes from a clk_divider instance.

Parameters:
N_CH, 2, number of independent sensor channels
STABLE_TICKS, 4, consecutive tick samples a new level must hold before it is accepted (>=1)
CNT_W, $clog2(STABLE_TICKS+1), width of the per-channel stability counter (derived, not overridden)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-low
tick  input  1  one-clk-wide sample enable from clk_divider
sensor_raw  input  N_CH  asynchronous raw sensor levels
sensor_db  output  N_CH  debounced level per channel
rise  output  N_CH  one-clk strobe when sensor_db[i] goes 0->1
fall  output  N_CH  one-clk strobe when sensor_db[i] goes 1->0

Behaviour:
- Reset: rst==0 at a clk edge clears both sync flops, puts every channel in S_LOW, and sets cnt=0, sensor_db=0, rise=0, fall=0. Reset is sampled only on clk; there is no async path.
- Reset mid-operation: pending counts are discarded and no rise/fall strobe is emitted in the reset cycle or the cycle after it.
- Sync: two-flop synchroniser per channel produces s[i]. Only s[i] is used downstream.
- Per-channel FSM states: S_LOW, S_WAIT_HIGH, S_HIGH, S_WAIT_LOW.
  - S_LOW: if s==1, go to S_WAIT_HIGH and set cnt=0. Otherwise stay.
  - S_WAIT_HIGH:
    - if s==0, go to S_LOW and set cnt=0 (glitch rejected, no strobe).
    - else if tick and cnt==STABLE_TICKS-1, go to S_HIGH, set cnt=0, and assert rise[i] for one cycle.
    - else if tick, cnt++.
  - S_HIGH: mirror of S_LOW on s==0, going to S_WAIT_LOW.
  - S_WAIT_LOW: mirror of S_WAIT_HIGH. It returns to S_HIGH on s==1, or goes to S_LOW with a fall[i] strobe.
- sensor_db[i] is 1 in S_HIGH and S_WAIT_LOW, and 0 otherwise. It is registered and changes in the same cycle its rise/fall strobe is high.
- Simultaneous events: a level mismatch and a tick in the same cycle of a WAIT state resolve as mismatch (abort). A tick in the cycle a channel enters a WAIT state is not counted.
- Latency: a clean step on sensor_raw reaches sensor_db after 2 clk (sync) + 1 clk (enter WAIT) + STABLE_TICKS ticks. The output updates on the clk edge that samples the final tick.
- STABLE_TICKS==1: the first tick while in WAIT accepts the level.
- Counter bounds: cnt never exceeds STABLE_TICKS-1, so there is no wrap-around.
- Channels are fully independent. Both channels may strobe in the same cycle. rise[i] and fall[i] are never high together.

Decomposition:
- Shared package debounce_pkg holds:
  - the state enum db_state_t (S_LOW, S_WAIT_HIGH, S_HIGH, S_WAIT_LOW), 2-bit logic;
  - the function is_high(db_state_t).
- Sub-module debounce_channel contains the synchroniser, the counter and the FSM for one channel, with ports clk, rst, tick, raw, level, rise, fall.
- sensor_debouncer instantiates N_CH debounce_channel instances with a generate loop.

Test Plan:
1. Hold rst=0 for 3 clk with sensor_raw=2'b11 -> sensor_db=00, rise=fall=00 throughout reset and 1 clk after.
2. STABLE_TICKS=4, tick every 4 clk, sensor_raw[0] steps 0->1 and holds -> rise[0] pulses exactly once, sensor_db[0]=1 on the edge sampling the 4th tick after entering S_WAIT_HIGH; sensor_db[1] stays 0.
3. Apply a 3-tick-long high pulse on sensor_raw[1], then low -> sensor_db[1] stays 0, no rise/fall strobes.
4. From S_HIGH on ch0, bounce low/high every 2 clk for 20 clk, then hold low -> sensor_db[0] stays 1 during the bounce; a single fall[0] strobe follows 4 ticks after the last transition.
5. Drive both channels 0->1 on the same clk -> rise=2'b11 in the same cycle, sensor_db=2'b11.
6. Assert rst=0 while ch0 is in S_WAIT_HIGH with cnt=2, release, and keep raw high -> no strobe during reset; the count restarts from 0 and rise[0] follows a full 4 ticks after the re-sync.
